mips_regfile: RTL

- 32-entry, 32-bit MIPS general-purpose register file for the single-cycle datapath.
- Sits directly upstream of the ALU:
  - ReadData1 drives ALU_A.
  - ReadData2 drives ALU_B through the ALUSrc mux.
- Write-back comes from the ALUOut/memory mux.
- Two asynchronous read ports, one synchronous write port, and one asynchronous debug read port for bench and trace visibility.

---
 rtl/mips_pkg.sv | 22 ++
 rtl/mips_regfile_if.sv | 26 ++
 rtl/mips_regfile.sv | 63 ++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: register-file geometry, named registers, ALUctl encodings.
package mips_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int NUM_REGS   = 32;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;
    localparam logic [REG_ADDR_W-1:0] SP       = 5'd29;
    localparam logic [REG_ADDR_W-1:0] RA       = 5'd31;

    // Encodings shared with the ALU and the ALU control decoder
    typedef enum logic [3:0] {
        ALU_AND = 4'd0,
        ALU_OR  = 4'd1,
        ALU_ADD = 4'd2,
        ALU_SUB = 4'd6,
        ALU_SLT = 4'd7,
        ALU_NOR = 4'd12
    } alu_ctl_t;

endpackage

// File: rtl/mips_regfile_if.sv
// Register-file access bundle: two read ports, one write port, one debug read port.
// master = datapath/bench side, slave = register file.
interface mips_regfile_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] ReadReg1;
    logic [ADDR_W-1:0] ReadReg2;
    logic [ADDR_W-1:0] WriteReg;
    logic [DATA_W-1:0] WriteData;
    logic              RegWrite;
    logic [ADDR_W-1:0] DbgReg;
    logic [DATA_W-1:0] ReadData1;
    logic [DATA_W-1:0] ReadData2;
    logic [DATA_W-1:0] DbgData;

    modport master (
        output ReadReg1, ReadReg2, WriteReg, WriteData, RegWrite, DbgReg,
        input  ReadData1, ReadData2, DbgData
    );

    modport slave (
        input  ReadReg1, ReadReg2, WriteReg, WriteData, RegWrite, DbgReg,
        output ReadData1, ReadData2, DbgData
    );
endinterface

// File: rtl/mips_regfile.sv
// MIPS GPR file: 2 async read ports + async debug port, 1 write port, zero read latency, 1-cycle write.
// No backpressure; reg 0 reads as 0. `define MIPS_REGFILE_BYPASS_EN adds WriteData write-through on ReadData1/2.
module mips_regfile
    import mips_pkg::*;
#(
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mips_regfile_if.slave        rf
);

    localparam int                NREGS     = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];

    logic [ADDR_W-1:0] rd_addr [2];
    logic [DATA_W-1:0] rd_data [2];

    always_comb begin
        regs_d = regs_q;
        if (rf.RegWrite && (rf.WriteReg != ZERO_ADDR)) begin
            regs_d[rf.WriteReg] = rf.WriteData;
        end
    end

    // Reset holds the array at zero, so writes presented during reset are dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rd_addr[0] = rf.ReadReg1;
    assign rd_addr[1] = rf.ReadReg2;

    for (genvar p = 0; p < 2; p++) begin : g_rd
        logic byp_hit;
`ifdef MIPS_REGFILE_BYPASS_EN
        assign byp_hit = rst_n && rf.RegWrite &&
                         (rd_addr[p] == rf.WriteReg) && (rf.WriteReg != ZERO_ADDR);
`else
        assign byp_hit = 1'b0;
`endif
        assign rd_data[p] = (rd_addr[p] == ZERO_ADDR) ? '0 :
                            byp_hit                   ? rf.WriteData :
                                                        regs_q[rd_addr[p]];
    end

    assign rf.ReadData1 = rd_data[0];
    assign rf.ReadData2 = rd_data[1];

    // Debug port always shows committed state, never the in-flight write
    assign rf.DbgData = (rf.DbgReg == ZERO_ADDR) ? '0 : regs_q[rf.DbgReg];

endmodule
